uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmit path. It sits directly upstream of the 8-bit serializer and drives that serializer's ser_en and parallel data. It consumes the serializer's ser_data and ser_done, and muxes start, data, optional parity and stop bits onto the line. One line bit is sent per clk cycle; clk is the bit-rate clock.

Parameters:
STOP_BITS, 1, number of stop bits per frame; legal values are 1 or 2.
DATA_TMO, 8, DATA-state cycle count at which ser_done must be seen; otherwise the frame is aborted.

Ports:
clk  input  1  bit-rate clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-low
tx_data  input  8  byte to transmit
tx_valid  input  1  request; sampled on rising clk while the block can accept
par_en  input  1  1 = parity bit inserted; latched with the byte
par_typ  input  1  0 = even, 1 = odd; latched with the byte
ser_data  input  1  serial data bit from the serializer
ser_done  input  1  serializer last-bit flag
ser_en  output  1  one-cycle start pulse to the serializer
p_data  output  8  byte presented to the serializer; held stable for the whole frame
tx_out  output  1  UART line output; idle high
busy  output  1  frame in progress
buf_full  output  1  holding buffer occupied; constant 0 without the macro
ser_err  output  1  one-cycle pulse on serializer timeout

Behaviour:
- Reset (rst=0, asynchronous) puts outputs and state in these values:
  - state=IDLE, tx_out=1, busy=0, ser_en=0, p_data=0, buf_full=0, ser_err=0.
  - Parity and config registers are cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- Serializer contract, a fixed fact of the neighbouring block:
  - ser_en is a 1-cycle pulse.
  - bit0 appears on ser_data in the cycle after the pulse; bits 1..7 follow on consecutive cycles.
  - ser_done is high during the bit7 cycle.
- States: IDLE, START, DATA, PARITY, STOP. State, counters and the latched config are registered. tx_out is a combinational mux of registered signals only:
  - IDLE → 1
  - START → 0
  - DATA → ser_data
  - PARITY → par_bit
  - STOP → 1
- IDLE:
  - tx_valid=1 at edge E0 → START.
  - Same edge: p_data<=tx_data, par_cfg<=par_en/par_typ, par_bit<=(^tx_data)^par_typ, ser_en<=1, busy<=1.
- START: lasts 1 cycle (E0..E1). ser_en returns to 0 at E1. → DATA.
- DATA:
  - A 4-bit counter increments each cycle.
  - ser_done=1 at an edge → PARITY if par_cfg enabled, else STOP.
  - Counter reaches DATA_TMO without ser_done → STOP, with ser_err pulsed 1 cycle. The frame still completes its stop bit(s).
- PARITY: lasts 1 cycle → STOP.
- STOP:
  - Lasts STOP_BITS cycles, then → IDLE, and busy drops on the same edge.
  - Without the macro, tx_valid is ignored whenever busy=1.
- Frame length is 10 + par_en + (STOP_BITS-1) cycles, counted from the cycle after E0.
- Latency: tx_valid sampled at E0 → line low from E0 to E1.
- Simultaneous ser_done and timeout in the same cycle: ser_done wins and ser_err stays 0.
- Parity bit values: even parity = XOR of the data bits; odd parity = its inverse.

Optional Feature:
Macro UART_TX_BUF_EN.
- Defined: adds a one-entry holding buffer.
  - tx_valid is accepted whenever buf_full=0, including while busy=1.
  - Accept while busy: byte and config go to the buffer, and buf_full<=1.
  - On the last STOP cycle with buf_full=1, go straight to START, loading the buffer contents and pulsing ser_en. There is no IDLE cycle between frames; buf_full clears on the same edge.
  - Accept in IDLE with the buffer empty starts the frame directly; the buffer is not used.
- Not defined:
  - No buffer; buf_full is tied to 0.
  - tx_valid is accepted only in IDLE.

Test Plan:
1. tx_data=0xA5, par_en=1, par_typ=0, STOP_BITS=1 → tx_out over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; busy high for those 11 cycles; one ser_en pulse.
2. tx_data=0x03, par_en=1, par_typ=1 → parity bit = 1; tx_data=0xFF, par_en=0 → 10-cycle frame 0,1,1,1,1,1,1,1,1,1.
3. STOP_BITS=2, tx_data=0x00, par_en=0 → 0 ×9, then 1,1; busy drops after the 11th cycle.
4. Serializer stub that never raises ser_done → ser_err pulses once after DATA_TMO=8 DATA cycles, then a stop bit, then IDLE with tx_out=1.
5. rst driven low during DATA bit3 of 0x5A → tx_out=1, busy=0, state IDLE immediately. A following request for 0x5A sends a clean full frame.
6. With UART_TX_BUF_EN: send 0x11, then tx_valid 0x22 while busy → buf_full=1. The 0x22 start bit follows the 0x11 stop bit with no idle cycle, and buf_full clears at that START edge. Without the macro, the second tx_valid is dropped.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame controller for the UART transmit path.
//
// Sequences START, DATA, optional PARITY and STOP bits onto tx_out, one bit
// per clk cycle (clk is the bit-rate clock). It kicks the downstream 8-bit
// serializer with a one-cycle ser_en pulse, presents the byte on p_data for
// the whole frame, and forwards ser_data to the line during DATA. If the
// serializer never raises ser_done, the frame is cut short after DATA_TMO
// DATA cycles, ser_err pulses, and the stop bit(s) are still sent.
//
// Optional build macro UART_TX_BUF_EN: adds a one-entry holding buffer so a
// request can be accepted while a frame is in flight. The next frame then
// starts straight out of the last stop bit with no idle cycle in between.
//
// Ports:
//   clk       bit-rate clock, rising edge
//   rst       asynchronous reset, active low
//   tx_data   byte to transmit
//   tx_valid  transmit request
//   par_en    insert parity bit (latched with the byte)
//   par_typ   0 = even, 1 = odd (latched with the byte)
//   ser_data  serial bit from the serializer
//   ser_done  serializer last-bit flag
//   ser_en    one-cycle start pulse to the serializer
//   p_data    byte presented to the serializer
//   tx_out    UART line, idle high
//   busy      frame in progress
//   buf_full  holding buffer occupied (always 0 without UART_TX_BUF_EN)
//   ser_err   one-cycle pulse on serializer timeout
module uart_tx_ctrl #(
    parameter int STOP_BITS = 1,
    parameter int DATA_TMO  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic       ser_data,
    input  logic       ser_done,
    output logic       ser_en,
    output logic [7:0] p_data,
    output logic       tx_out,
    output logic       busy,
    output logic       buf_full,
    output logic       ser_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Counter values seen on the final DATA / STOP cycle.
    localparam logic [3:0] TMO_LAST  = 4'(DATA_TMO - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] p_data_n;
    // Parity type is folded into par_bit at load time, so only the enable
    // needs to be kept as frame config.
    logic       par_cfg, par_cfg_n;
    logic       par_bit, par_bit_n;
    logic       ser_en_n, busy_n, ser_err_n;

    // Frame load request and the values it loads.
    logic       ld_tx;
    logic [7:0] ld_data;
    logic       ld_pen, ld_pbit;

`ifdef UART_TX_BUF_EN
    logic       ld_buf;
    logic [7:0] buf_data, buf_data_n;
    logic       buf_pen, buf_pen_n;
    logic       buf_pbit, buf_pbit_n;
    logic       buf_full_q, buf_full_n;
    assign buf_full = buf_full_q;
`else
    assign buf_full = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        p_data_n  = p_data;
        par_cfg_n = par_cfg;
        par_bit_n = par_bit;
        ser_en_n  = 1'b0;
        busy_n    = busy;
        ser_err_n = 1'b0;
        ld_tx     = 1'b0;
        ld_data   = tx_data;
        ld_pen    = par_en;
        ld_pbit   = (^tx_data) ^ par_typ;
`ifdef UART_TX_BUF_EN
        ld_buf     = 1'b0;
        buf_data_n = buf_data;
        buf_pen_n  = buf_pen;
        buf_pbit_n = buf_pbit;
        buf_full_n = buf_full_q;
`endif

        case (state)
            IDLE: begin
`ifdef UART_TX_BUF_EN
                // A byte parked on the very last stop edge is drained here.
                if (buf_full_q)
                    ld_buf = 1'b1;
                else
`endif
                if (tx_valid)
                    ld_tx = 1'b1;
            end
            START: begin
                state_n = DATA;
                cnt_n   = '0;
            end
            DATA: begin
                // ser_done takes priority over a timeout in the same cycle.
                if (ser_done) begin
                    state_n = par_cfg ? PARITY : STOP;
                    cnt_n   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_n   = STOP;
                    cnt_n     = '0;
                    ser_err_n = 1'b1;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            PARITY: begin
                state_n = STOP;
                cnt_n   = '0;
            end
            STOP: begin
                if (cnt == STOP_LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
`ifdef UART_TX_BUF_EN
                    if (buf_full_q)
                        ld_buf = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

`ifdef UART_TX_BUF_EN
        // Park a request that arrives mid-frame.
        if (busy && tx_valid && !buf_full_q) begin
            buf_data_n = tx_data;
            buf_pen_n  = par_en;
            buf_pbit_n = (^tx_data) ^ par_typ;
            buf_full_n = 1'b1;
        end
        if (ld_buf) begin
            ld_data    = buf_data;
            ld_pen     = buf_pen;
            ld_pbit    = buf_pbit;
            buf_full_n = 1'b0;
        end
        if (ld_tx || ld_buf) begin
`else
        if (ld_tx) begin
`endif
            state_n   = START;
            cnt_n     = '0;
            p_data_n  = ld_data;
            par_cfg_n = ld_pen;
            par_bit_n = ld_pbit;
            ser_en_n  = 1'b1;
            busy_n    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            p_data  <= '0;
            par_cfg <= 1'b0;
            par_bit <= 1'b0;
            ser_en  <= 1'b0;
            busy    <= 1'b0;
            ser_err <= 1'b0;
`ifdef UART_TX_BUF_EN
            buf_data   <= '0;
            buf_pen    <= 1'b0;
            buf_pbit   <= 1'b0;
            buf_full_q <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            p_data  <= p_data_n;
            par_cfg <= par_cfg_n;
            par_bit <= par_bit_n;
            ser_en  <= ser_en_n;
            busy    <= busy_n;
            ser_err <= ser_err_n;
`ifdef UART_TX_BUF_EN
            buf_data   <= buf_data_n;
            buf_pen    <= buf_pen_n;
            buf_pbit   <= buf_pbit_n;
            buf_full_q <= buf_full_n;
`endif
        end
    end

    // Line mux: registered state plus the serializer's bit.
    always_comb begin
        tx_out = 1'b1;
        case (state)
            START:   tx_out = 1'b0;
            DATA:    tx_out = ser_data;
            PARITY:  tx_out = par_bit;
            default: tx_out = 1'b1;
        endcase
    end

endmodule
